uart_receiver_control: RTL and testbench

Sequencing controller for the UART receive path. Synchronises the raw serial line, runs the ×16 oversampling timebase, detects and validates start bits, and drives the `baudx16`, `midbit` and `shift_en` strobes of the downstream receive shift register. Flags each completed frame with a one-cycle `rx_valid` pulse or a `frame_err` pulse, aligned with the shift register's parallel output update.

---
 rtl/uart_receiver_control.sv | 163 ++++++++++++++++
 tb/tb_uart_receiver_control.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_control.sv
// UART receive sequencer: line synchroniser, x16 oversampling timebase and
// start/data/stop framing FSM that strobes an external receive shift register.
module uart_receiver_control #(
  parameter int BAUD_DIV = 54
) (
  input  logic clk_i,
  input  logic rstb_i,
  input  logic RxD,
  output logic rxd_o,
  output logic baudx16,
  output logic midbit,
  output logic shift_en,
  output logic busy,
  output logic rx_valid,
  output logic frame_err
);

  localparam int DIV_W = $clog2(BAUD_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  logic [1:0]       sync_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             baud_r;
  logic [2:0]       state_r, state_s;
  logic [3:0]       sample_r, sample_s;
  logic [2:0]       bit_r, bit_s;
  logic             valid_r, valid_s;
  logic             ferr_r, ferr_s;
  logic             line_s;

  assign line_s = sync_r[1];

  // two-flop synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], RxD};
    end
  end

  // free-running prescaler; never realigned to incoming frames
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      div_cnt_r <= '0;
      baud_r    <= 1'b0;
    end else begin
      baud_r <= (div_cnt_r == DIV_LAST);
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
    end
  end

  // framing FSM next-state; only advances on oversample ticks
  always_comb begin
    state_s  = state_r;
    sample_s = sample_r;
    bit_s    = bit_r;
    valid_s  = 1'b0;
    ferr_s   = 1'b0;
    if (baud_r) begin
      case (state_r)
        ST_IDLE: begin
          if (!line_s) begin
            state_s  = ST_START;
            sample_s = 4'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_START: begin
          // start-bit centre: a high line here means the falling edge was a glitch
          if (sample_r == 4'd7) begin
            if (!line_s) begin
              state_s  = ST_DATA;
              sample_s = 4'd0;
              bit_s    = 3'd0;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            sample_s = sample_r + 4'd1;
          end
        end
        ST_DATA: begin
          sample_s = sample_r + 4'd1;
          if (sample_r == 4'd15) begin
            bit_s = bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              state_s = ST_STOP;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            bit_s = bit_r;
          end
        end
        ST_STOP: begin
          sample_s = sample_r + 4'd1;
          if (sample_r == 4'd15) begin
            if (line_s) begin
              valid_s = 1'b1;
              state_s = ST_IDLE;
            end else begin
              ferr_s  = 1'b1;
              state_s = ST_WAIT;
            end
          end else begin
            state_s = ST_STOP;
          end
        end
        ST_WAIT: begin
          // a held-low line (break) must rise before a new start is accepted
          if (line_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state and frame-status pulse registers
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_r  <= ST_IDLE;
      sample_r <= 4'd0;
      bit_r    <= 3'd0;
      valid_r  <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      sample_r <= sample_s;
      bit_r    <= bit_s;
      valid_r  <= valid_s;
      ferr_r   <= ferr_s;
    end
  end

  assign rxd_o     = line_s;
  assign baudx16   = baud_r;
  assign midbit    = ((state_r == ST_DATA) || (state_r == ST_STOP)) && (sample_r == 4'd15);
  assign shift_en  = (state_r == ST_STOP);
  assign busy      = (state_r != ST_IDLE);
  assign rx_valid  = valid_r;
  assign frame_err = ferr_r;

endmodule

// File: tb/tb_uart_receiver_control.sv
// Bench for uart_receiver_control: serial frames against a scoreboard of
// expected outcomes, plus a BAUD_DIV=54 instance for prescaler timing.
module tb_uart_receiver_control;

  localparam int D   = 4;
  localparam int BIT = 16 * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb, rstb54, rxd;
  logic rxd_o, baudx16, midbit, shift_en, busy, rx_valid, frame_err;
  logic rxd_o54, b54, mid54, sh54, busy54, val54, ferr54;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned cyc = 0;

  uart_receiver_control #(.BAUD_DIV(D)) dut (
    .clk_i(clk), .rstb_i(rstb), .RxD(rxd), .rxd_o(rxd_o), .baudx16(baudx16),
    .midbit(midbit), .shift_en(shift_en), .busy(busy), .rx_valid(rx_valid),
    .frame_err(frame_err)
  );

  uart_receiver_control #(.BAUD_DIV(54)) dut54 (
    .clk_i(clk), .rstb_i(rstb54), .RxD(rxd), .rxd_o(rxd_o54), .baudx16(b54),
    .midbit(mid54), .shift_en(sh54), .busy(busy54), .rx_valid(val54),
    .frame_err(ferr54)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    bit          err;
    logic [7:0]  data;
    int unsigned t0;
  } exp_t;

  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // downstream shift register: LSB-first shifts on data centres, load on stop centre
  logic [7:0] sr = 8'h00;
  logic [7:0] sr_out = 8'h00;
  always @(posedge clk) begin
    if (midbit && baudx16) begin
      if (shift_en) sr_out <= sr;
      else          sr <= {rxd_o, sr[7:1]};
    end
  end

  int strobes = 0;
  bit prev_pulse = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int unsigned lat;
    if (!rstb) begin
      strobes = 0;
      prev_pulse = 1'b0;
    end else begin
      if (midbit && baudx16) begin
        strobes++;
        if (shift_en) begin
          check_eq("strobes_per_frame", strobes, 9);
          strobes = 0;
        end
      end
      if (rx_valid || frame_err) begin
        check_eq("pulse_width", prev_pulse, 0);
        check_eq("pulse_excl", rx_valid & frame_err, 0);
        check_eq("pulse_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          lat = cyc - e.t0;
          check_eq("pulse_is_err", frame_err, e.err);
          if (!e.err) check_eq("rx_data", sr_out, e.data);
          check_eq($sformatf("latency_%0d_in_window", lat),
                   (lat >= 152*D + 3) && (lat <= 153*D + 2), 1);
        end
      end
      prev_pulse = rx_valid || frame_err;
    end
  end

  int ticks54 = 0;
  int unsigned last54 = 0;
  bit have54 = 1'b0;
  bit prev54 = 1'b0;
  always @(negedge clk) begin
    if (rstb54 && b54) begin
      if (have54) check_eq("b54_period", cyc - last54, 54);
      check_eq("b54_width", prev54, 0);
      check_eq("b54_mid_needs_busy", mid54 & ~busy54, 0);
      check_eq("b54_shift_needs_busy", sh54 & ~busy54, 0);
      check_eq("b54_pulse_excl", val54 & ferr54, 0);
      if (rstb) check_eq("b54_sync_match", rxd_o54, rxd_o);
      last54 = cyc;
      have54 = 1'b1;
      ticks54++;
    end
    prev54 = b54;
  end

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit track);
    if (track) sb_q.push_back('{err: ~stop, data: d, t0: cyc});
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    hold(stop, BIT);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    rstb = 1'b0;
    rstb54 = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {baudx16, midbit, shift_en, busy, rx_valid, frame_err}, 0);
    check_eq("reset_rxd_o", rxd_o, 1);
    rstb = 1'b1;
    rstb54 = 1'b1;
    hold(1'b1, 2*BIT);
    check_eq("idle_busy", busy, 0);

    send_frame(8'hA5, 1'b1, 1'b1);
    hold(1'b1, BIT);

    // short low glitch must be rejected at the start-bit centre
    hold(1'b0, 3*D);
    check_eq("glitch_busy_hi", busy, 1);
    hold(1'b1, 12*D);
    check_eq("glitch_busy_lo", busy, 0);
    check_eq("glitch_no_strobe", strobes, 0);

    send_frame(8'h3C, 1'b0, 1'b1);
    hold(1'b0, 20*BIT);
    check_eq("break_busy", busy, 1);
    hold(1'b0, 20*BIT);
    hold(1'b1, 2*BIT);
    check_eq("break_released", busy, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    hold(1'b1, BIT);

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    hold(1'b1, 2*BIT);

    // abort 0x96 halfway through data bit 4
    d = 8'h96;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(d[i], BIT);
    hold(d[4], BIT/2);
    rstb = 1'b0;
    #1;
    check_eq("abort_outs", {baudx16, midbit, shift_en, busy, rx_valid, frame_err}, 0);
    check_eq("abort_rxd_o", rxd_o, 1);
    @(negedge clk);
    hold(1'b1, 4);
    rstb = 1'b1;
    hold(1'b1, 2*BIT);
    check_eq("abort_idle", busy, 0);
    send_frame(8'h69, 1'b1, 1'b1);
    hold(1'b1, BIT);

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, 1'b1);
      if (!stop) hold(1'b1, BIT);
      hold(1'b1, $urandom_range(0, 2)*BIT + $urandom_range(0, BIT-1));
      if ($urandom_range(0, 3) == 0) begin
        hold(1'b0, $urandom_range(1, 5)*D);
        hold(1'b1, 12*D);
        check_eq("rand_glitch_idle", busy, 0);
        check_eq("rand_glitch_no_strobe", strobes, 0);
      end
    end
    hold(1'b1, 2*BIT);

    for (int k = 0; k < 60000 && ticks54 < 1000; k++) @(negedge clk);
    check_eq("b54_ticks_reached", ticks54 >= 1000, 1);
    check_eq("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
